sub32_pipe: RTL

SUB32_PIPE -- requirements
Module: sub32_pipe

---
 rtl/sub32_pipe_if.sv | 28 ++
 rtl/sub32_pipe.sv | 113 +++++++++++
 2 files changed

// File: rtl/sub32_pipe_if.sv
// sub32_pipe_if: operand/result handshake bundle for sub32_pipe.
// The master side offers operands and accepts results; the slave side is the
// subtractor pipeline itself.
interface sub32_pipe_if #(
  parameter int DATA_WIDTH = 31
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH:0]   a;
  logic [DATA_WIDTH:0]   b;
  logic                  bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH:0]   d;
  logic                  bout;
  logic                  zero;
  logic                  ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, zero, ovf
  );
endinterface

// File: rtl/sub32_pipe.sv
// sub32_pipe: two-stage pipelined subtractor d = a - b - bin with
// valid/ready handshaking on both sides.
// Stage 1 subtracts the low halves and keeps the high operand halves; stage 2
// finishes the high half with the stage-1 borrow and produces the flags.
// Optional feature macro: SUB32_FLAGS_EN -- when defined, zero and ovf are
// computed and registered; otherwise both ports are tied to 0.
module sub32_pipe #(
  parameter int DATA_WIDTH = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  sub32_pipe_if.slave bus
);

  localparam int W  = DATA_WIDTH + 1;
  localparam int LW = W / 2;
  localparam int HW = W - LW;

  // Stage-1 state: low-half result plus the untouched high operand halves
  logic          s1_v_q;
  logic [LW-1:0] s1_dlo_q;
  logic          s1_blo_q;
  logic [HW-1:0] s1_ahi_q;
  logic [HW-1:0] s1_bhi_q;

  // Stage-2 state: the full result as seen on the outputs
  logic          s2_v_q;
  logic [W-1:0]  s2_d_q;
  logic          s2_bout_q;

  // Load enables: a stage may load whenever it is empty or its consumer moves
  logic          s2_en;
  logic          s1_en;

  // Next-state arithmetic; the extra top bit of each difference is the borrow
  logic [LW:0]   lo_diff_d;
  logic [HW:0]   hi_diff_d;
  logic [W-1:0]  d_d;

  assign s2_en = ~s2_v_q | bus.out_ready;
  assign s1_en = ~s1_v_q | s2_en;

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = s2_v_q;
  assign bus.d         = s2_d_q;
  assign bus.bout      = s2_bout_q;

  assign lo_diff_d = {1'b0, bus.a[LW-1:0]} - {1'b0, bus.b[LW-1:0]}
                   - (LW+1)'(bus.bin);
  assign hi_diff_d = {1'b0, s1_ahi_q} - {1'b0, s1_bhi_q}
                   - (HW+1)'(s1_blo_q);
  assign d_d       = {hi_diff_d[HW-1:0], s1_dlo_q};

  // Stage 1: capture the low-half difference/borrow and the high halves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_dlo_q <= '0;
      s1_blo_q <= 1'b0;
      s1_ahi_q <= '0;
      s1_bhi_q <= '0;
    end else if (s1_en) begin
      s1_v_q   <= bus.in_valid;
      s1_dlo_q <= lo_diff_d[LW-1:0];
      s1_blo_q <= lo_diff_d[LW];
      s1_ahi_q <= bus.a[W-1:LW];
      s1_bhi_q <= bus.b[W-1:LW];
    end
  end

  // Stage 2: finish the high half with the stage-1 borrow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_d_q    <= '0;
      s2_bout_q <= 1'b0;
    end else if (s2_en) begin
      s2_v_q    <= s1_v_q;
      s2_d_q    <= d_d;
      s2_bout_q <= hi_diff_d[HW];
    end
  end

`ifdef SUB32_FLAGS_EN
  logic s2_zero_q;
  logic s2_ovf_q;
  logic zero_d;
  logic ovf_d;

  // Overflow: operand signs differ and the result sign differs from a's sign
  assign zero_d = (d_d == '0);
  assign ovf_d  = (s1_ahi_q[HW-1] ^ s1_bhi_q[HW-1])
                & (hi_diff_d[HW-1] ^ s1_ahi_q[HW-1]);

  // Stage-2 flags move in lockstep with the stage-2 result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_zero_q <= 1'b0;
      s2_ovf_q  <= 1'b0;
    end else if (s2_en) begin
      s2_zero_q <= zero_d;
      s2_ovf_q  <= ovf_d;
    end
  end

  assign bus.zero = s2_zero_q;
  assign bus.ovf  = s2_ovf_q;
`else
  assign bus.zero = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

endmodule
